key_click_decoder: RTL
======================

// Module: key_click_decoder
// PURPOSE
//  Consumes the debounced press pulse (key_flag) and the raw active-low key level for one push-button.
//  Classifies each gesture as single click, double click or long press, and emits one 1-cycle pulse per gesture.
//  Sits directly downstream of the key debouncer; its pulses drive LED/mode-control logic.
// PARAMETERS
//  CNT_W    26           width of hold/window counter
//  LONG_CNT 26'd49_999_999  hold cycles to qualify long press (1 s @ 50 MHz)
//  DBL_CNT  26'd14_999_999  max cycles from release to 2nd press for double click (300 ms)
//  REL_CNT  20'd999_999     consecutive high cycles on key_in to qualify release (20 ms)
// PORTS
//  sys_clk      in  1  system clock, all logic on posedge
//  sys_rst      in  1  synchronous reset, active-high
//  key_in       in  1  raw key level, active-low, asynchronous to sys_clk
//  key_flag     in  1  debounced press pulse, 1 sys_clk cycle wide, sampled on posedge
//  single_click out 1  1-cycle pulse: single click recognised
//  double_click out 1  1-cycle pulse: double click recognised
//  long_press   out 1  1-cycle pulse: long press recognised (while still held)
//  busy         out 1  high whenever FSM is not IDLE
// BEHAVIOUR
//  Reset (sys_rst=1 at posedge): state=IDLE; all counters 0; sync regs 1; all outputs 0. Mid-gesture reset aborts, no pulse.
//  key_in passes through 2-FF synchroniser (reset value 1) -> key_s.
//  Release qualifier: rel_cnt clears when key_s=0, increments when key_s=1, saturates at REL_CNT;
//   rel_ok = (rel_cnt==REL_CNT). A bounce (key_s=0) restarts qualification.
//  FSM states / transitions (cnt = CNT_W-bit counter, cleared on every state change):
//   IDLE      : key_flag -> PRESS1.
//   PRESS1    : cnt+1 per cycle; cnt==LONG_CNT -> LONG_HOLD, pulse long_press;
//               else rel_ok -> WAIT2. Both in same cycle: long press wins.
//   WAIT2     : cnt+1 per cycle; key_flag -> PRESS2, pulse double_click;
//               else cnt==DBL_CNT -> IDLE, pulse single_click. Simultaneous: key_flag wins (double).
//   PRESS2    : rel_ok -> IDLE. No further classification.
//   LONG_HOLD : rel_ok -> IDLE. No further pulses.
//  key_flag ignored in PRESS1, PRESS2, LONG_HOLD.
//  cnt never wraps: it changes state at its terminal value before overflow.
//  Outputs registered: pulse high exactly the cycle after the posedge that takes the transition decision; 1 cycle wide.
//  single_click/double_click/long_press mutually exclusive; at most one pulse per gesture.
//  busy registered, = (next state != IDLE) from the same edge as the state register.
//  Latency: single_click = release qualification + DBL_CNT+1 cycles after WAIT2 entry + 1.
// STRUCTURE
//  Shared header key_pkg.vh: FSM state localparams (IDLE=3'd0, PRESS1=3'd1, WAIT2=3'd2, PRESS2=3'd3, LONG_HOLD=3'd4).
//  Also in key_pkg.vh: default timing constants shared with the debouncer.
//  One sub-module: key_release_qual (2-FF sync + rel_cnt, outputs key_s, rel_ok), parameter REL_CNT.
//  Top holds FSM, cnt, output registers.
// TESTING (bench params: LONG_CNT=20, DBL_CNT=10, REL_CNT=3)
//  1 key_flag pulse, key_in low 5 cycles, then high -> single_click 1 pulse after WAIT2 times out.
//    No other pulses; busy drops in the same cycle.
//  2 press/release, then 2nd key_flag 4 cycles into WAIT2 -> double_click pulse next cycle.
//    single_click never asserted; after release, IDLE.
//  3 key_flag, key_in held low 30 cycles -> long_press pulse once (cnt==20).
//    Nothing on release; back in IDLE after 3 high cycles.
//  4 release bounce: key_in high 2, low 1, high 3 -> rel_ok only after last 3 high cycles.
//    WAIT2 entered then, not earlier.
//  5 key_flag coincident with cnt==DBL_CNT in WAIT2 -> double_click, no single_click.
//  6 sys_rst asserted 1 cycle mid-PRESS1 -> outputs 0, busy 0, IDLE.
//    Subsequent release produces no pulse.

Source files
------------

// File: rtl/key_click_decoder_pkg.sv
// Shared types and default timing constants for the push-button gesture decoder.
// The timing defaults assume a 50 MHz system clock and are shared with the key debouncer.
package key_click_decoder_pkg;

  localparam int unsigned CNT_W_DEF = 26;
  localparam int unsigned REL_W     = 20;

  localparam logic [CNT_W_DEF-1:0] LONG_CNT_DEF = 26'd49_999_999;
  localparam logic [CNT_W_DEF-1:0] DBL_CNT_DEF  = 26'd14_999_999;
  localparam logic [REL_W-1:0]     REL_CNT_DEF  = 20'd999_999;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HOLD = 3'd4
  } key_state_e;

endpackage

// File: rtl/key_click_decoder_if.sv
// Key inputs and gesture pulse outputs of one push-button decoder.
interface key_click_decoder_if;

  logic key_in;
  logic key_flag;
  logic single_click;
  logic double_click;
  logic long_press;
  logic busy;

  modport master (
    output key_in, key_flag,
    input  single_click, double_click, long_press, busy
  );

  modport slave (
    input  key_in, key_flag,
    output single_click, double_click, long_press, busy
  );

endinterface

// File: rtl/key_click_decoder_release_qual.sv
// Release qualifier: synchronises the raw active-low key level and flags a
// release once the key has read high for REL_CNT consecutive cycles.
module key_click_decoder_release_qual
  import key_click_decoder_pkg::*;
#(
  parameter logic [REL_W-1:0] REL_CNT = REL_CNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic rel_ok_c
);

  logic             key_sync;
  logic             key_s;
  logic [REL_W-1:0] rel_cnt;

  // Two-flop synchroniser, idles at the released level.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_sync <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_sync <= key_in;
      key_s    <= key_sync;
    end
  end

  // Any low sample (bounce) restarts qualification; saturates at the threshold.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rel_cnt <= '0;
    end else if (!key_s) begin
      rel_cnt <= '0;
    end else if (rel_cnt != REL_CNT) begin
      rel_cnt <= rel_cnt + REL_W'(1);
    end
  end

  assign rel_ok_c = (rel_cnt == REL_CNT);

endmodule

// File: rtl/key_click_decoder.sv
// Push-button gesture classifier: turns debounced presses into single-click,
// double-click and long-press pulses, one registered 1-cycle pulse per gesture.
module key_click_decoder
  import key_click_decoder_pkg::*;
#(
  parameter int unsigned      CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_CNT_DEF),
  parameter logic [CNT_W-1:0] DBL_CNT  = CNT_W'(DBL_CNT_DEF),
  parameter logic [REL_W-1:0] REL_CNT  = REL_CNT_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  key_click_decoder_if.slave  bus
);

  key_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             rel_ok_c;
  logic             single_q;
  logic             double_q;
  logic             long_q;
  logic             busy_q;

  key_click_decoder_release_qual #(
    .REL_CNT (REL_CNT)
  ) u_release_qual (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (bus.key_in),
    .rel_ok_c (rel_ok_c)
  );

  // Gesture FSM; cnt restarts on every state change so it never wraps.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.key_flag) begin
            state  <= ST_PRESS1;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_PRESS1: begin
          if (cnt == LONG_CNT) begin
            state  <= ST_LONG_HOLD;
            cnt    <= '0;
            long_q <= 1'b1;
          end else if (rel_ok_c) begin
            state <= ST_WAIT2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // A second press on the timeout cycle still counts as a double click.
        ST_WAIT2: begin
          if (bus.key_flag) begin
            state    <= ST_PRESS2;
            cnt      <= '0;
            double_q <= 1'b1;
          end else if (cnt == DBL_CNT) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            single_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PRESS2, ST_LONG_HOLD: begin
          if (rel_ok_c) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.single_click = single_q;
  assign bus.double_click = double_q;
  assign bus.long_press   = long_q;
  assign bus.busy         = busy_q;

endmodule
